// File: rtl/gb_timer.sv
// gb_timer: memory-mapped DIV/TIMA/TMA/TAC timer with one-clk overflow interrupt
module gb_timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04,
  parameter int          STEP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  d_in,
  input  logic        write,
  output logic [7:0]  d_out,
  output logic        hit,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, PEND, RELOAD} state_t;
  state_t      state;
  logic [15:0] sys_cnt, sys_next;
  logic [7:0]  tima, tma;
  logic [2:0]  tac, tac_next;
  logic        prev_sig, sig_next, tick, tick_pend;
  logic        div_wr, tima_wr, tma_wr, tac_wr;
  always_comb begin
    hit      = (addr & 16'hFFFC) == BASE_ADDR;
    div_wr   = write & hit & (addr[1:0] == 2'd0);
    tima_wr  = write & hit & (addr[1:0] == 2'd1);
    tma_wr   = write & hit & (addr[1:0] == 2'd2);
    tac_wr   = write & hit & (addr[1:0] == 2'd3);
    sys_next = div_wr ? 16'h0000 : sys_cnt + 16'(STEP);
    tac_next = tac_wr ? d_in[2:0] : tac;
    sig_next = tac_next[2] & (tac_next[1:0] == 2'b00 ? sys_next[9] :
                              tac_next[1:0] == 2'b01 ? sys_next[3] :
                              tac_next[1:0] == 2'b10 ? sys_next[5] : sys_next[7]);
    tick     = prev_sig & ~sig_next;
    d_out    = !hit ? 8'hFF :
               addr[1:0] == 2'd0 ? sys_cnt[15:8] :
               addr[1:0] == 2'd1 ? tima :
               addr[1:0] == 2'd2 ? tma : {5'b11111, tac};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sys_cnt   <= '0;
      tima      <= '0;
      tma       <= '0;
      tac       <= '0;
      prev_sig  <= 1'b0;
      tick_pend <= 1'b0;
      irq       <= 1'b0;
    end else begin
      sys_cnt  <= sys_next;
      tac      <= tac_next;
      prev_sig <= sig_next;
      irq      <= 1'b0;
      if (tma_wr) tma <= d_in;
      case (state)
        IDLE: begin
          tick_pend <= 1'b0;
          if (tima_wr) tima <= d_in;
          else if (tick | tick_pend) begin
            if (tima == 8'hFF) begin
              tima  <= 8'h00;
              state <= PEND;
            end else tima <= tima + 8'd1;
          end
        end
        PEND: begin
          if (tima_wr) begin
            tima  <= d_in;
            state <= IDLE;
          end else begin
            tima  <= tma;
            irq   <= 1'b1;
            state <= RELOAD;
          end
        end
        RELOAD: begin
          // a tick landing here is deferred to the following IDLE clk
          tima      <= tma_wr ? d_in : tma;
          tick_pend <= tick;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer: directed self-checking bench for gb_timer
module tb_gb_timer;
  logic        clk = 1'b0, rst = 1'b0, write = 1'b0;
  logic [15:0] addr = 16'hFF04;
  logic [7:0]  d_in = 8'h00;
  logic [7:0]  d_out;
  logic        hit, irq;
  int          checks = 0, failures = 0, n;
  localparam logic [15:0] DIV = 16'hFF04, TIMA = 16'hFF05, TMA = 16'hFF06, TAC = 16'hFF07;

  gb_timer dut (.clk(clk), .rst(rst), .addr(addr), .d_in(d_in), .write(write),
                .d_out(d_out), .hit(hit), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; d_in = d; write = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string tag);
    addr = a;
    #1;
    chk(tag, d_out, exp);
  endtask

  // leaves the timer so that the very next edge overflows TIMA (sys_cnt=12, TAC=101)
  task automatic ovf_setup();
    wr(TAC, 8'h00);
    wr(DIV, 8'h00);
    wr(TIMA, 8'hFF);
    wr(TAC, 8'h05);
    step();
  endtask

  initial begin
    #1;
    rd(DIV, 8'h00, "rst_div");
    rd(TAC, 8'hF8, "rst_tac");
    chk("rst_irq", {7'd0, irq}, 8'h00);
    chk("rst_hit", {7'd0, hit}, 8'h01);
    rd(16'hFF08, 8'hFF, "miss_read");
    chk("miss_hit", {7'd0, hit}, 8'h00);
    #10 rst = 1'b1;
    for (int i = 0; i < 64; i++) step();
    rd(DIV, 8'h01, "div_64");
    wr(DIV, 8'hAA);
    rd(DIV, 8'h00, "div_clear");
    wr(16'hFF03, 8'h07);
    rd(TAC, 8'hF8, "miss_write");

    wr(TIMA, 8'h00);
    wr(TAC, 8'h05);
    rd(TAC, 8'hFD, "tac_read");
    for (int i = 0; i < 4; i++) step();
    rd(TIMA, 8'h01, "tima_4");
    for (int i = 0; i < 16; i++) step();
    rd(TIMA, 8'h05, "tima_20");

    wr(TMA, 8'hFE);
    ovf_setup();
    step();
    rd(TIMA, 8'h00, "pend_tima");
    chk("pend_irq", {7'd0, irq}, 8'h00);
    step();
    rd(TIMA, 8'hFE, "reload_tima");
    chk("reload_irq", {7'd0, irq}, 8'h01);
    step();
    chk("irq_one_clk", {7'd0, irq}, 8'h00);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      n += int'(irq);
    end
    chk("no_extra_irq", 8'(n), 8'h00);
    rd(TIMA, 8'h00, "second_ovf");
    step();
    chk("second_irq", {7'd0, irq}, 8'h01);
    step();

    ovf_setup();
    step();
    rd(TIMA, 8'h00, "cancel_pend");
    wr(TIMA, 8'h42);
    rd(TIMA, 8'h42, "cancel_tima");
    n = int'(irq);
    for (int i = 0; i < 3; i++) begin
      step();
      n += int'(irq);
    end
    chk("cancel_no_irq", 8'(n), 8'h00);
    rd(TIMA, 8'h43, "cancel_counts");

    wr(TMA, 8'h55);
    ovf_setup();
    step();
    step();
    chk("reload2_irq", {7'd0, irq}, 8'h01);
    wr(TIMA, 8'h11);
    rd(TIMA, 8'h55, "reload_ignore_tima");
    chk("reload2_irq_off", {7'd0, irq}, 8'h00);
    ovf_setup();
    step();
    step();
    chk("reload3_irq", {7'd0, irq}, 8'h01);
    wr(TMA, 8'h33);
    rd(TIMA, 8'h33, "reload_tma_tima");
    rd(TMA, 8'h33, "reload_tma");
    chk("reload3_irq_off", {7'd0, irq}, 8'h00);

    wr(TAC, 8'h00);
    wr(DIV, 8'h00);
    wr(TIMA, 8'h00);
    wr(TAC, 8'h04);
    rd(TAC, 8'hFC, "tac_bit9");
    for (int i = 0; i < 126; i++) step();
    rd(DIV, 8'h02, "div_512");
    rd(TIMA, 8'h00, "bit9_no_tick");
    wr(DIV, 8'h00);
    rd(TIMA, 8'h01, "div_spurious");
    for (int i = 0; i < 128; i++) step();
    rd(TIMA, 8'h01, "bit9_hold");
    wr(TAC, 8'h00);
    rd(TIMA, 8'h02, "tac_spurious");
    rd(TAC, 8'hF8, "tac_off");

    ovf_setup();
    step();
    #2 rst = 1'b0;
    #1;
    chk("abort_irq", {7'd0, irq}, 8'h00);
    rd(TIMA, 8'h00, "abort_tima");
    #1 rst = 1'b1;
    step();
    chk("abort_no_irq", {7'd0, irq}, 8'h00);
    rd(TIMA, 8'h00, "abort_tima_hold");
    rd(DIV, 8'h00, "abort_div");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gb_timer.md
Name: gb_timer

Overview:
- Memory-mapped DIV/TIMA/TMA/TAC timer on the sm83 core bus, downstream of the core.
- Consumes the core's addr, write and data-out; supplies read data back to the core's data-in mux.
- Produces a one-cycle timer interrupt request for the interrupt flag logic.
- One clk equals one M-cycle of the core.

Parameters:
- BASE_ADDR, 16'hFF04, address of DIV. TIMA, TMA and TAC follow at +1, +2 and +3.
- STEP, 4, amount added to the internal system counter per clk (T-cycles per M-cycle).

Ports:
- clk  input  1  core clock; one rising edge per M-cycle
- rst  input  1  asynchronous, active-low reset
- addr  input  16  address from core
- d_in  input  8  write data from core
- write  input  1  write strobe; qualifies d_in at posedge clk
- d_out  output  8  read data for the register selected by addr
- hit  output  1  addr is within BASE_ADDR..BASE_ADDR+3
- irq  output  1  timer interrupt request; one-clk pulse

Behaviour:
- State:
  - sys_cnt[15:0]; DIV = sys_cnt[15:8]
  - tima[7:0], tma[7:0], tac[2:0]
  - ovf_state: IDLE, PEND, RELOAD
  - prev_sig[0:0], irq register
- Reset: rst low asynchronously clears all state to 0 and state to IDLE. d_out then reads per the decode below; irq=0.
- sys_cnt: += STEP each clk, 16-bit wrap.
  - A write to DIV sets sys_cnt to 0 instead of incrementing; the written data is ignored.
- Tick signal: sig = tac[2] & sys_cnt[sel], where sel = 9, 3, 5, 7 for tac[1:0] = 00, 01, 10, 11.
  - sig is evaluated on the post-update (next) sys_cnt and tac.
  - tick = prev_sig & !sig_next (falling edge). prev_sig <= sig_next.
  - Consequence: a DIV write or a TAC change that drops sig from 1 to 0 produces a spurious tick. This is required.
- On tick in IDLE:
  - tima < FF: tima+1.
  - tima = FF: tima becomes 00 and the state goes to PEND.
- PEND, one clk, tima reads 00:
  - Next clk: tima <= tma, irq <= 1, state goes to RELOAD.
  - A TIMA write during PEND: tima takes the written value, the reload and irq are cancelled, and the state returns to IDLE.
- RELOAD, one clk: irq is high this clk only.
  - TIMA writes are ignored; tima holds tma.
  - A TMA write updates tma and also tima in the same edge.
  - Next clk: IDLE, irq <= 0.
  - A tick arriving in RELOAD is applied next clk (prev_sig is still tracked).
- Writes in IDLE:
  - A TIMA write overrides any tick in the same clk; the write wins.
  - A TMA write takes effect at the next edge.
  - A TAC write stores d_in[2:0].
- Reads are combinational:
  - DIV: sys_cnt[15:8]
  - TIMA: tima
  - TMA: tma
  - TAC: {5'b11111, tac}
  - Not hit: 8'hFF
- hit = (addr & 16'hFFFC) == BASE_ADDR, valid for the default BASE_ADDR alignment. Writes when hit=0 have no effect.
- The irq pulse is exactly one clk; the consumer latches it into IF. Overlapping overflows are impossible, since the minimum tick period is 4 clks.
- Reset asserted mid-PEND or mid-RELOAD aborts the sequence; no irq.

Test Plan:
- Reset, then 64 clks with no writes: DIV read = 01. Write DIV: next read = 00.
- TAC=101, TIMA=00: TIMA increments every 4 clks and reads 05 after 20 clks.
- TMA=FE, TIMA=FF, TAC=101, then wait for the tick:
  - TIMA reads 00 for 1 clk, then FE.
  - irq is high for exactly 1 clk, aligned with the reload.
  - No further irq until the next overflow.
- Overflow to PEND, then write TIMA=42 in the PEND clk: TIMA=42 and irq never asserts.
- Overflow reaches RELOAD, then in that clk write TIMA=11 and TMA=33: TIMA=33, TMA=33, irq=1 for one clk.
- TAC=100 (bit 9), run until sys_cnt[9]=1, then write DIV: TIMA increments by 1 immediately. Write TAC=000 while sig=1: one spurious tick.
